sample_byte_packer: RTL
=======================

Name: sample_byte_packer

Overview:
- Upstream feeder for ser_dser: accepts 22-bit capture samples and emits them as a 3-byte, MSB-first byte stream on an 8-bit valid/ready interface that drives the ser_dser 8-bit input.
- Internal sample FIFO decouples the capture source from byte-rate backpressure.
- Framing marker bits identify the first byte of each sample. A frame counter supports bring-up and debug.

Parameters:
- DEPTH, 4, sample FIFO depth in entries; power of 2, minimum 2
- MARKER, 2'b10, 2-bit tag placed in bits [7:6] of the first byte of each frame
- CNT_W, 16, width of frames_sent counter

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- sample_in  input  22  capture sample data
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  FIFO can accept a sample this cycle
- byte_out  output  8  byte toward ser_dser in
- byte_valid  output  1  byte_out is valid
- byte_ready  input  1  consumer accepts byte_out this cycle
- frame_start  output  1  high while byte_out is byte 0 of a frame
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- frames_sent  output  CNT_W  count of fully transmitted frames, wraps

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - byte_out=0, byte_valid=0, frame_start=0, fifo_level=0, frames_sent=0.
  - FSM returns to IDLE and FIFO pointers go to 0.
  - sample_ready=1 as soon as reset deasserts.
- Push:
  - sample_ready = (fifo_level != DEPTH), decoded from registered count only. It does not depend on same-cycle pop or byte_ready.
  - A push occurs on a clk edge with sample_valid && sample_ready.
  - sample_valid while full is not an error. The sample is simply not taken, and the source must hold it.
- Frame format for sample s:
  - B0 = {MARKER, s[21:16]}
  - B1 = s[15:8]
  - B2 = s[7:0]
- FSM states: IDLE, B0, B1, B2.
  - IDLE: if FIFO non-empty, pop and load the shift register, then go to B0. Empty FIFO: stay.
  - B0, B1, B2: byte_valid=1. byte_out and frame_start come from registers (frame_start=1 only in B0).
  - Advance B0→B1→B2 on byte_ready. Hold state and outputs unchanged while byte_ready=0.
  - B2 with byte_ready: increment frames_sent (mod 2^CNT_W). Then, if FIFO non-empty, pop and go to B0 with no bubble cycle; otherwise go to IDLE with byte_valid=0.
- Latency: a sample pushed at edge N into an empty FIFO with the FSM in IDLE gives B0 valid after edge N+1. A same-cycle push-to-pop bypass is not provided.
- Sustained throughput is 1 byte/cycle (1 sample per 3 cycles) with byte_ready held high.
- Simultaneous push and pop: fifo_level is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Reset mid-frame: the partial frame and FIFO contents are discarded with no partial increment of frames_sent. The first sample after reset starts at B0.
- Outputs are stable while byte_valid && !byte_ready. byte_valid never drops without a handshake, except on reset.

Test Plan:
- Single sample: push sample_in=22'h2ABCDE with byte_ready=1 → byte_out sequence 8'hAA (frame_start=1), 8'hBC, 8'hDE on consecutive cycles; B0 appears the cycle after the push edge; frames_sent=1; byte_valid=0 afterwards.
- Fill/backpressure: byte_ready=0, present 6 back-to-back samples → 5 accepted (1 in the sequencer, 4 in the FIFO), fifo_level=4, sample_ready=0, and the 6th is held. Raise byte_ready → the 6th is accepted one cycle after the first B2 pop frees an entry, and 6 frames emerge in order.
- No-bubble throughput: queue 2 samples (22'h000001, 22'h3FFFFF), byte_ready=1 → 6 consecutive valid cycles: 80,00,01,BF,FF,FF.
- Stall stability: toggle byte_ready 0/1 every cycle during a frame → byte_out and frame_start constant across every stalled cycle, and no byte is skipped or duplicated.
- Reset mid-frame: assert reset after B0 of 22'h123456 is accepted → all outputs zero asynchronously (before the next edge), frames_sent=0. The next sample 22'h0000FF yields 80,00,FF.
- Counter wrap: with CNT_W=2, send 5 frames → frames_sent 1,2,3,0,1.

Source files
------------

// File: rtl/sample_byte_packer.sv
// Packs 22-bit capture samples into a 3-byte MSB-first stream.
// A small sample FIFO sits in front of a B0/B1/B2 byte sequencer.
module sample_byte_packer #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [1:0]  MARKER = 2'b10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [21:0]              sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         frames_sent
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [21:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_shift;
    logic [7:0]      r_byte;
    logic            r_fs;
    logic [CNT_W-1:0] r_frames;

    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_advance;
    logic [21:0] w_head;

    assign sample_ready = (r_count != FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = sample_valid && sample_ready;
    assign w_advance    = byte_valid && byte_ready;
    assign w_head       = r_mem[r_rd_ptr];

    assign byte_valid  = (r_state != StIdle);
    assign byte_out    = r_byte;
    assign frame_start = r_fs;
    assign fifo_level  = r_count;
    assign frames_sent = r_frames;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Popping is decided from the registered count only, so a sample pushed
    // this cycle is never bypassed straight into the sequencer.
    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StB0;
                end
            end
            StB0: if (byte_ready) w_state_d = StB1;
            StB1: if (byte_ready) w_state_d = StB2;
            StB2: begin
                if (byte_ready) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StB0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte   <= '0;
            r_shift  <= '0;
            r_fs     <= 1'b0;
            r_frames <= '0;
        end else begin
            if ((r_state == StB2) && byte_ready) begin
                r_frames <= r_frames + 1'b1;
            end
            if (w_pop) begin
                r_byte  <= {MARKER, w_head[21:16]};
                r_shift <= w_head[15:0];
                r_fs    <= 1'b1;
            end else if (w_advance) begin
                r_fs <= 1'b0;
                case (r_state)
                    StB0:    r_byte <= r_shift[15:8];
                    StB1:    r_byte <= r_shift[7:0];
                    default: r_byte <= '0;
                endcase
            end
        end
    end

endmodule
